maxnet_controller: RTL

Sequencing FSM for the 4-lane Maxnet winner-take-all datapath (four 32-bit activation registers fed by four PUs, a finish detector and a result mux). On `start` it initialises the X/W memories, loads the input vector into the activation registers, then repeatedly waits out PU latency and writes PU outputs back until the datapath reports a single survivor (`is_finished`) or an iteration limit expires. It is the only driver of `init_x`, `init_w`, `load_a` and `load_sel`.

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/latency_counter.sv | 35 +++
 rtl/maxnet_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_pkg
// Description : Shared types and default constants for the Maxnet sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package maxnet_pkg;

    localparam int c_PU_LAT   = 2;
    localparam int c_MAX_ITER = 63;
    localparam int c_CNT_W    = 6;
    localparam int c_LAT_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_CHECK  = 3'd3,
        S_WAIT   = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : latency_counter
// Description : Down-counter timing the PU pipeline latency between updates.
// Revision    : 1.0 - initial release
// ============================================================================
module latency_counter
    import maxnet_pkg::*;
#(
    parameter int PU_LAT = c_PU_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    logic [c_LAT_W-1:0] r_count;

    // Loading PU_LAT-1 makes expiry coincide with the last wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LAT_W'(PU_LAT - 1);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/maxnet_controller.sv
`default_nettype none
// ============================================================================
// Module      : maxnet_controller
// Description : Sequencing FSM for the 4-lane Maxnet winner-take-all datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int PU_LAT   = c_PU_LAT,
    parameter int MAX_ITER = c_MAX_ITER,
    parameter int CNT_W    = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_finished,
    output logic             init_x,
    output logic             init_w,
    output logic             load_sel,
    output logic             load_a,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_count
);

    localparam logic [CNT_W-1:0] c_ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t           r_state;
    state_t           w_next;
    logic             r_init;
    logic             r_load_sel;
    logic             r_load_a;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_iter;

    logic             w_init;
    logic             w_load_sel;
    logic             w_load_a;
    logic             w_busy;
    logic             w_done;
    logic             w_expired;
    logic             w_lat_load;
    logic             w_lat_dec;
    logic             w_accept;
    logic             w_at_limit;

    assign w_lat_load = (r_state == S_CHECK);
    assign w_lat_dec  = (r_state == S_WAIT);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_at_limit = (r_iter == c_ITER_LIMIT);

    latency_counter #(
        .PU_LAT    (PU_LAT)
    ) u_latency_counter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_lat_load),
        .i_dec     (w_lat_dec),
        .o_expired (w_expired)
    );

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_init     <= 1'b0;
            r_load_sel <= 1'b0;
            r_load_a   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_init     <= w_init;
            r_load_sel <= w_load_sel;
            r_load_a   <= w_load_a;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iter    <= '0;
                r_timeout <= 1'b0;
            end else if (r_state == S_UPDATE) begin
                r_iter <= r_iter + 1'b1;
            end
            // A finish seen in the same CHECK takes priority over the limit.
            if ((r_state == S_CHECK) && !is_finished && w_at_limit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_INIT;
            S_INIT:   w_next = S_LOAD;
            S_LOAD:   w_next = S_CHECK;
            S_CHECK: begin
                if (is_finished || w_at_limit) w_next = S_DONE;
                else                           w_next = S_WAIT;
            end
            S_WAIT:   if (w_expired) w_next = S_UPDATE;
            S_UPDATE: w_next = S_CHECK;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_init     = (w_next == S_INIT);
        w_load_sel = (w_next == S_LOAD);
        w_load_a   = (w_next == S_LOAD) || (w_next == S_UPDATE);
        w_busy     = (w_next != S_IDLE);
        w_done     = (w_next == S_DONE);
    end

    assign init_x     = r_init;
    assign init_w     = r_init;
    assign load_sel   = r_load_sel;
    assign load_a     = r_load_a;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign iter_count = r_iter;

endmodule
`default_nettype wire
